// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and constants for the instruction fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   typedef enum logic [1:0] {
      START = 2'd0,
      RUN   = 2'd1,
      HALT  = 2'd2
   } fetch_state_t;

   localparam logic [31:0] C_RESET_PC   = 32'h0040_0000;
   localparam logic [31:0] C_FAULT_WORD = 32'hDEAD_BEEF;
   localparam logic [31:0] C_NOP_WORD   = 32'h0000_0033;

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Brief    : IF/ID pipeline register (instr, pc, pc4, valid) with load,
//            bubble and hold. Reset leaves a bubble in the register.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_reg
   import fetch_pkg::*;
#(
   parameter logic [31:0] NOP_WORD = C_NOP_WORD
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic        i_bubble,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_pc4,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc4,
   output logic        o_valid
);

   logic [31:0] r_instr;
   logic [31:0] r_pc;
   logic [31:0] r_pc4;
   logic        r_valid;

   // Bubble takes precedence over load; neither asserted means hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr <= NOP_WORD;
         r_pc    <= 32'd0;
         r_pc4   <= 32'd0;
         r_valid <= 1'b0;
      end else if (i_bubble) begin
         r_instr <= NOP_WORD;
         r_pc    <= 32'd0;
         r_pc4   <= 32'd0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_instr <= i_instr;
         r_pc    <= i_pc;
         r_pc4   <= i_pc4;
         r_valid <= 1'b1;
      end
   end

   assign o_instr = r_instr;
   assign o_pc    = r_pc;
   assign o_pc4   = r_pc4;
   assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : Fetch stage: drives the instruction memory address, captures the
//            returned word into IF/ID, handles stall and redirect, and halts
//            on a fault word or a misaligned redirect target.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = C_RESET_PC,
   parameter logic [31:0] FAULT_WORD = C_FAULT_WORD,
   parameter logic [31:0] NOP_WORD   = C_NOP_WORD
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] if_id_instr_o,
   output logic [31:0] if_id_pc_o,
   output logic [31:0] if_id_pc4_o,
   output logic        if_id_valid_o,
   output logic        fault_o,
   output logic        halted_o,
   output logic [31:0] fetch_count_o
);

   fetch_state_t r_state;
   fetch_state_t w_state_next;
   logic [31:0]  r_pc;
   logic [31:0]  w_pc_next;
   logic [31:0]  w_pc4;
   logic         r_fault;
   logic         w_fault_next;
   logic [31:0]  r_count;
   logic [31:0]  w_count_next;
   logic         w_load;
   logic         w_bubble;

   // pc+4 wraps naturally at 2^32; wrap is not a fault.
   assign w_pc4     = r_pc + 32'd4;
   assign imem_addr = r_pc;

   // State, PC, sticky fault and capture counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= START;
         r_pc    <= RESET_PC;
         r_fault <= 1'b0;
         r_count <= 32'd0;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         r_fault <= w_fault_next;
         r_count <= w_count_next;
      end
   end

   // Next-state and IF/ID control: redirect > stall > fault > normal fetch.
   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_fault_next = r_fault;
      w_count_next = r_count;
      w_load       = 1'b0;
      w_bubble     = 1'b0;
      case (r_state)
         START: begin
            w_state_next = RUN;
         end
         RUN: begin
            if (redirect_i) begin
               w_bubble = 1'b1;
               if (redirect_pc_i[1:0] == 2'b00) begin
                  w_pc_next = redirect_pc_i;
               end else begin
                  // Misaligned target: PC holds so the bad request is visible.
                  w_fault_next = 1'b1;
                  w_state_next = HALT;
               end
            end else if (!stall_i) begin
               if (imem_rdata == FAULT_WORD) begin
                  // PC holds so imem_addr keeps showing the faulting address.
                  w_bubble     = 1'b1;
                  w_fault_next = 1'b1;
                  w_state_next = HALT;
               end else begin
                  w_load    = 1'b1;
                  w_pc_next = w_pc4;
                  if (r_count != 32'hFFFF_FFFF) begin
                     w_count_next = r_count + 32'd1;
                  end
               end
            end
         end
         HALT: begin
            w_fault_next = 1'b1;
         end
         default: begin
            w_fault_next = 1'b1;
            w_state_next = HALT;
         end
      endcase
   end

   if_id_reg #(
      .NOP_WORD (NOP_WORD)
   ) u_if_id_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_load),
      .i_bubble (w_bubble),
      .i_instr  (imem_rdata),
      .i_pc     (r_pc),
      .i_pc4    (w_pc4),
      .o_instr  (if_id_instr_o),
      .o_pc     (if_id_pc_o),
      .o_pc4    (if_id_pc4_o),
      .o_valid  (if_id_valid_o)
   );

   assign fault_o       = r_fault;
   assign halted_o      = (r_state == HALT);
   assign fetch_count_o = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Scoreboard bench for instr_fetch: directed program walk plus
//            randomized stall/redirect traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

   localparam logic [31:0] RST_PC = 32'h0040_0000;
   localparam logic [31:0] NOP    = 32'h0000_0033;
   localparam logic [31:0] BAD    = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        stall_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'd0;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] if_id_instr_o;
   logic [31:0] if_id_pc_o;
   logic [31:0] if_id_pc4_o;
   logic        if_id_valid_o;
   logic        fault_o;
   logic        halted_o;
   logic [31:0] fetch_count_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   instr_fetch dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .if_id_instr_o (if_id_instr_o),
      .if_id_pc_o    (if_id_pc_o),
      .if_id_pc4_o   (if_id_pc4_o),
      .if_id_valid_o (if_id_valid_o),
      .fault_o       (fault_o),
      .halted_o      (halted_o),
      .fetch_count_o (fetch_count_o)
   );

   // Instruction memory: small program image, two synthetic mapped regions,
   // everything else reads as the fault word.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0040_0000: return 32'h3e80_2403;
         32'h0040_0004: return 32'h3ec0_2483;
         32'h0040_0008: return 32'h0000_0033;
         32'h0040_000C: return 32'h0084_8493;
         32'h0040_0010: return 32'hfe94_1ce3;
         32'h0040_0014: return 32'h0000_0013;
         32'h0040_0018: return 32'h0094_0533;
         32'h0040_001C: return 32'h00a0_2023;
         32'h0040_0020: return 32'h0000_006f;
         32'h0040_0024: return 32'h0010_0073;
         default: begin
            if (a[31:12] == 20'h10000 || a[31:12] == 20'hFFFFF)
               return {a[15:0], 16'h1337};
            return BAD;
         end
      endcase
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        valid;
      logic        fault;
      logic        halted;
      logic [31:0] count;
      logic [31:0] addr;
   } exp_t;

   exp_t q[$];
   exp_t e;

   // Behavioural model of the fetch stage.
   logic [31:0] m_pc, m_instr, m_pco, m_pc4, m_count;
   logic        m_valid, m_fault, m_halted, m_started;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_bubble();
      m_instr = NOP;
      m_pco   = 32'd0;
      m_pc4   = 32'd0;
      m_valid = 1'b0;
   endtask

   task automatic model_reset();
      m_pc      = RST_PC;
      m_count   = 32'd0;
      m_fault   = 1'b0;
      m_halted  = 1'b0;
      m_started = 1'b0;
      model_bubble();
   endtask

   task automatic model_step(input logic st, input logic rd, input logic [31:0] tgt);
      logic [31:0] w;
      if (!m_started) begin
         m_started = 1'b1;
      end else if (!m_halted) begin
         if (rd) begin
            model_bubble();
            if (tgt % 4 == 0) m_pc = tgt;
            else begin
               m_fault  = 1'b1;
               m_halted = 1'b1;
            end
         end else if (!st) begin
            w = mem_word(m_pc);
            if (w == BAD) begin
               model_bubble();
               m_fault  = 1'b1;
               m_halted = 1'b1;
            end else begin
               m_instr = w;
               m_pco   = m_pc;
               m_pc4   = m_pc + 32'd4;
               m_valid = 1'b1;
               m_pc    = m_pc + 32'd4;
               if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
            end
         end
      end
   endtask

   // One clock: drive inputs at the falling edge, record what the next
   // rising edge must produce, then move to the following falling edge.
   task automatic cycle(input logic st, input logic rd, input logic [31:0] tgt);
      exp_t x;
      stall_i       = st;
      redirect_i    = rd;
      redirect_pc_i = tgt;
      model_step(st, rd, tgt);
      x.instr  = m_instr;
      x.pc     = m_pco;
      x.pc4    = m_pc4;
      x.valid  = m_valid;
      x.fault  = m_fault;
      x.halted = m_halted;
      x.count  = m_count;
      x.addr   = m_pc;
      q.push_back(x);
      @(negedge clk);
   endtask

   // Asynchronous reset mid-cycle; outputs must settle before any clock edge.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst imem_addr", imem_addr, RST_PC);
      chk("rst instr", if_id_instr_o, NOP);
      chk("rst pc", if_id_pc_o, 32'd0);
      chk("rst pc4", if_id_pc4_o, 32'd0);
      chk("rst valid", {31'd0, if_id_valid_o}, 32'd0);
      chk("rst fault", {31'd0, fault_o}, 32'd0);
      chk("rst halted", {31'd0, halted_o}, 32'd0);
      chk("rst count", fetch_count_o, 32'd0);
      q.delete();
      model_reset();
      stall_i    = 1'b0;
      redirect_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: after each rising edge compare DUT state with the oldest expectation.
   always @(posedge clk) begin
      #1;
      if (rst_n && q.size() > 0) begin
         e = q.pop_front();
         chk("sb instr", if_id_instr_o, e.instr);
         chk("sb pc", if_id_pc_o, e.pc);
         chk("sb pc4", if_id_pc4_o, e.pc4);
         chk("sb valid", {31'd0, if_id_valid_o}, {31'd0, e.valid});
         chk("sb fault", {31'd0, fault_o}, {31'd0, e.fault});
         chk("sb halted", {31'd0, halted_o}, {31'd0, e.halted});
         chk("sb count", fetch_count_o, e.count);
         chk("sb imem_addr", imem_addr, e.addr);
      end
   end

   initial begin
      logic        st, rd;
      logic [31:0] tgt;

      @(negedge clk);
      do_reset();

      // Program walk: START edge, then two captures.
      cycle(0, 0, 0);
      chk("start no capture", {31'd0, if_id_valid_o}, 32'd0);
      cycle(0, 0, 0);
      cycle(0, 0, 0);
      chk("second capture", if_id_instr_o, 32'h3ec0_2483);
      chk("count two", fetch_count_o, 32'd2);

      // Stall for three cycles at 0x00400008.
      repeat (3) cycle(1, 0, 0);
      chk("stall instr", if_id_instr_o, 32'h3ec0_2483);
      chk("stall addr", imem_addr, 32'h0040_0008);
      chk("stall count", fetch_count_o, 32'd2);
      cycle(0, 0, 0);
      chk("post-stall pc", if_id_pc_o, 32'h0040_0008);

      // Redirect wins over stall.
      cycle(1, 1, 32'h0040_0018);
      chk("redirect bubble", {31'd0, if_id_valid_o}, 32'd0);
      cycle(0, 0, 0);
      chk("redirect target", if_id_instr_o, 32'h0094_0533);

      // Fall through to the unmapped word at 0x00400028.
      repeat (4) cycle(0, 0, 0);
      chk("fault addr", imem_addr, 32'h0040_0028);
      chk("fault flag", {31'd0, fault_o}, 32'd1);
      chk("fault halted", {31'd0, halted_o}, 32'd1);
      cycle(0, 1, 32'h0040_0000);
      chk("halt ignores redirect", imem_addr, 32'h0040_0028);

      // Misaligned redirect halts with PC held.
      do_reset();
      cycle(0, 0, 0);
      cycle(0, 0, 0);
      cycle(0, 1, 32'h0040_0002);
      chk("misaligned halted", {31'd0, halted_o}, 32'd1);
      chk("misaligned addr", imem_addr, 32'h0040_0004);
      cycle(1, 1, 32'h0040_0010);

      // PC wrap at the top of the address space.
      do_reset();
      cycle(0, 0, 0);
      cycle(0, 1, 32'hFFFF_FFFC);
      cycle(0, 0, 0);
      chk("wrap pc4", if_id_pc4_o, 32'd0);
      chk("wrap addr", imem_addr, 32'd0);

      // Randomized stall/redirect traffic.
      for (int r = 0; r < 6; r++) begin
         do_reset();
         for (int c = 0; c < 150; c++) begin
            st = ($urandom_range(0, 9) < 3);
            rd = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 7))
               0, 1, 2: tgt = 32'h0040_0000 + 32'd4 * $urandom_range(0, 9);
               3, 4:    tgt = 32'h1000_0000 + 32'd4 * $urandom_range(0, 1000);
               5, 6:    tgt = 32'hFFFF_FFE0 + 32'd4 * $urandom_range(0, 7);
               default: tgt = $urandom;
            endcase
            cycle(st, rd, tgt);
         end
      end

      for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
      #2;
      if (q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: got %0d pending, expected 0", q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
